// File: rtl/mem_stage.sv
// MEM pipeline stage: 3-state bus master (IDLE/REQ/DONE) with lane steering, load extension and timeout.
// Optional build macro MEM_ALIGN_CHECK_EN enables the misaligned-access trap; undefined, low address bits are ignored.
module mem_stage #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ALUresultin,
    input  logic [31:0] storedatain,
    input  logic [4:0]  rt_rddin,
    input  logic        MemReadin,
    input  logic        MemWritein,
    input  logic        MemtoRegin,
    input  logic        Regwritein,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    output logic [31:0] memrdataout,
    output logic [31:0] ALUresultout,
    output logic [4:0]  rt_rddout,
    output logic        MemtoRegout,
    output logic        Regwriteout,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        bus_err,
    output logic        misalign
);

    localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   rdata_q, addr_q, wdata_q;
    logic [3:0]    be_q;
    logic          req_q, we_q, busErr_q, misal_q, err_q, uns_q;
    logic [1:0]    off_q, size_q;

    logic          access;
    logic          misal_d;
    logic [3:0]    be_d;
    logic [31:0]   wdata_d;
    logic [7:0]    ldByte;
    logic [15:0]   ldHalf;
    logic [31:0]   ldExt;

    assign access = MemReadin | MemWritein;

    always_comb begin
        be_d    = 4'b1111;
        wdata_d = storedatain;
        case (mem_size)
            2'b00: begin
                be_d    = 4'b0001 << ALUresultin[1:0];
                wdata_d = {4{storedatain[7:0]}};
            end
            2'b01: begin
                be_d    = 4'b0011 << {ALUresultin[1], 1'b0};
                wdata_d = {2{storedatain[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = storedatain;
            end
        endcase
    end

`ifdef MEM_ALIGN_CHECK_EN
    assign misal_d = ((mem_size == 2'b01) && ALUresultin[0]) ||
                     (mem_size[1] && (ALUresultin[1:0] != 2'b00));
`else
    assign misal_d = 1'b0;
`endif

    // Lane select uses the access offset/size remembered at issue, since mem_addr is word aligned.
    always_comb begin
        case (off_q)
            2'd0:    ldByte = mem_rdata[7:0];
            2'd1:    ldByte = mem_rdata[15:8];
            2'd2:    ldByte = mem_rdata[23:16];
            default: ldByte = mem_rdata[31:24];
        endcase
        ldHalf = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            2'b00:   ldExt = {{24{~uns_q & ldByte[7]}}, ldByte};
            2'b01:   ldExt = {{16{~uns_q & ldHalf[15]}}, ldHalf};
            default: ldExt = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rdata_q  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            busErr_q <= 1'b0;
            misal_q  <= 1'b0;
            err_q    <= 1'b0;
            uns_q    <= 1'b0;
            off_q    <= '0;
            size_q   <= '0;
        end else begin
            busErr_q <= 1'b0;
            misal_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (access) begin
                        off_q  <= ALUresultin[1:0];
                        size_q <= mem_size;
                        uns_q  <= mem_unsigned;
                        if (misal_d) begin
                            misal_q <= 1'b1;
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                            we_q    <= 1'b0;
                            state_q <= DONE;
                        end else begin
                            err_q   <= 1'b0;
                            addr_q  <= {ALUresultin[31:2], 2'b00};
                            we_q    <= MemWritein;
                            be_q    <= be_d;
                            wdata_q <= wdata_d;
                            req_q   <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= REQ;
                        end
                    end
                end
                REQ: begin
                    // An ack in the last allowed cycle is taken in preference to the timeout.
                    if (mem_ack) begin
                        rdata_q <= we_q ? 32'd0 : ldExt;
                        req_q   <= 1'b0;
                        state_q <= DONE;
                    end else if (cnt_q == LAST_CNT) begin
                        busErr_q <= 1'b1;
                        err_q    <= 1'b1;
                        rdata_q  <= '0;
                        req_q    <= 1'b0;
                        state_q  <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall        = (state_q == IDLE) ? access : (state_q == REQ);
    assign memrdataout  = (state_q == DONE) ? rdata_q : 32'd0;
    assign Regwriteout  = Regwritein & ~((state_q == DONE) & err_q);
    assign ALUresultout = ALUresultin;
    assign rt_rddout    = rt_rddin;
    assign MemtoRegout  = MemtoRegin;
    assign mem_req      = req_q;
    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign mem_be       = be_q;
    assign bus_err      = busErr_q;
    assign misalign     = misal_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed and randomized accesses scored against a transaction-level model.
module tb_mem_stage;

    localparam int T = 16;

    logic        clk, rst;
    logic [31:0] ALUresultin, storedatain;
    logic [4:0]  rt_rddin;
    logic        MemReadin, MemWritein, MemtoRegin, Regwritein;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [31:0] memrdataout, ALUresultout;
    logic [4:0]  rt_rddout;
    logic        MemtoRegout, Regwriteout, stall;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        bus_err, misalign;

    int nChecks = 0;
    int nPass   = 0;

    // Per-cycle expectations published by the driver and consumed by the compare process.
    logic        expValid = 1'b0;
    logic        expStall, expReq, expRegwr, expBusErr, expMis;
    logic [31:0] expRdata;
    logic        expBusValid;
    logic [31:0] expAddr, expWdata;
    logic [3:0]  expBe;
    logic        expWe;

    mem_stage #(.TIMEOUT_CYC(T)) dut (
        .clk(clk), .rst(rst),
        .ALUresultin(ALUresultin), .storedatain(storedatain), .rt_rddin(rt_rddin),
        .MemReadin(MemReadin), .MemWritein(MemWritein), .MemtoRegin(MemtoRegin),
        .Regwritein(Regwritein), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
        .memrdataout(memrdataout), .ALUresultout(ALUresultout), .rt_rddout(rt_rddout),
        .MemtoRegout(MemtoRegout), .Regwriteout(Regwriteout), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .bus_err(bus_err), .misalign(misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Access geometry: first byte lane and number of lanes touched.
    function automatic int laneLo(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'b00) return int'(addr[1:0]);
        if (size == 2'b01) return addr[1] ? 2 : 0;
        return 0;
    endfunction

    function automatic int laneCnt(input logic [1:0] size);
        if (size == 2'b00) return 1;
        if (size == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] modelBe(input logic [1:0] size, input logic [31:0] addr);
        logic [3:0] be;
        int lo, n;
        lo = laneLo(size, addr);
        n  = laneCnt(size);
        for (int i = 0; i < 4; i++) be[i] = (i >= lo) && (i < lo + n);
        return be;
    endfunction

    function automatic logic [31:0] modelWdata(input logic [1:0] size, input logic [31:0] sd);
        if (size == 2'b00) return {24'd0, sd[7:0]} * 32'h0101_0101;
        if (size == 2'b01) return {16'd0, sd[15:0]} * 32'h0001_0001;
        return sd;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [31:0] rd, input logic [31:0] addr,
                                              input logic [1:0] size, input logic uns);
        logic [31:0] v, mask;
        int n;
        n = laneCnt(size);
        if (n == 4) return rd;
        mask = (n == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
        v = (rd >> (8 * laneLo(size, addr))) & mask;
        if (!uns && ((v & ((mask >> 1) + 1)) != 0)) v = v | ~mask;
        return v;
    endfunction

    function automatic logic modelMis(input logic [1:0] size, input logic [31:0] addr);
`ifdef MEM_ALIGN_CHECK_EN
        if (size == 2'b01) return addr[0];
        if (size[1]) return addr[1:0] != 2'b00;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    always @(negedge clk) begin
        if (expValid) begin
            checkOutput("stall", {31'd0, stall}, {31'd0, expStall});
            checkOutput("mem_req", {31'd0, mem_req}, {31'd0, expReq});
            checkOutput("memrdataout", memrdataout, expRdata);
            checkOutput("Regwriteout", {31'd0, Regwriteout}, {31'd0, expRegwr});
            checkOutput("bus_err", {31'd0, bus_err}, {31'd0, expBusErr});
            checkOutput("misalign", {31'd0, misalign}, {31'd0, expMis});
            checkOutput("ALUresultout", ALUresultout, ALUresultin);
            checkOutput("rt_rddout", {27'd0, rt_rddout}, {27'd0, rt_rddin});
            checkOutput("MemtoRegout", {31'd0, MemtoRegout}, {31'd0, MemtoRegin});
            if (expBusValid) begin
                checkOutput("mem_addr", mem_addr, expAddr);
                checkOutput("mem_be", {28'd0, mem_be}, {28'd0, expBe});
                checkOutput("mem_we", {31'd0, mem_we}, {31'd0, expWe});
                checkOutput("mem_wdata", mem_wdata, expWdata);
            end
        end
    end

    task automatic setExp(input logic s, input logic r, input logic [31:0] d, input logic rw,
                          input logic be, input logic mi, input logic bv);
        expValid = 1'b1; expStall = s; expReq = r; expRdata = d; expRegwr = rw;
        expBusErr = be; expMis = mi; expBusValid = bv;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Presents one instruction (or an idle slot when neither read nor write) and scripts the bus
    // response; ackAt = k acks in the k-th REQ cycle, 0 never acks.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] rd,
                                 input logic rdEn, input logic wrEn, input logic m2r, input logic regw,
                                 input logic [1:0] size, input logic uns, input int ackAt,
                                 input logic [31:0] rdata);
        logic        err;
        int          nReq;
        logic [31:0] loadVal;
        ALUresultin = addr; storedatain = sd; rt_rddin = rd; MemReadin = rdEn; MemWritein = wrEn;
        MemtoRegin = m2r; Regwritein = regw; mem_size = size; mem_unsigned = uns;
        mem_rdata = $urandom;
        if (!rdEn && !wrEn) begin
            mem_ack = 1'($urandom);
            setExp(1'b0, 1'b0, 32'd0, regw, 1'b0, 1'b0, 1'b0);
            nextCycle();
            mem_ack = 1'b0;
            return;
        end
        mem_ack = 1'b0;
        setExp(1'b1, 1'b0, 32'd0, regw, 1'b0, 1'b0, 1'b0);
        nextCycle();
        if (modelMis(size, addr)) begin
            setExp(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            nextCycle();
            return;
        end
        expAddr  = {addr[31:2], 2'b00};
        expBe    = modelBe(size, addr);
        expWe    = wrEn;
        expWdata = modelWdata(size, sd);
        loadVal  = modelLoad(rdata, addr, size, uns);
        nReq     = (ackAt == 0 || ackAt > T) ? T : ackAt;
        for (int c = 1; c <= nReq; c++) begin
            setExp(1'b1, 1'b1, 32'd0, regw, 1'b0, 1'b0, 1'b1);
            mem_ack   = (c == ackAt);
            mem_rdata = (c == ackAt) ? rdata : $urandom;
            nextCycle();
        end
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        err = (ackAt == 0 || ackAt > T);
        setExp(1'b0, 1'b0, (err || wrEn) ? 32'd0 : loadVal, regw & ~err, err, 1'b0, 1'b0);
        nextCycle();
    endtask

    initial begin
        rst = 1'b1; ALUresultin = '0; storedatain = '0; rt_rddin = '0; MemReadin = 1'b0;
        MemWritein = 1'b0; MemtoRegin = 1'b0; Regwritein = 1'b0; mem_size = '0;
        mem_unsigned = 1'b0; mem_ack = 1'b0; mem_rdata = '0;

        checkOutput("model_ld_sbyte", modelLoad(32'h8011_2233, 32'h103, 2'b00, 1'b0), 32'hFFFF_FF80);
        checkOutput("model_ld_ubyte", modelLoad(32'h8011_2233, 32'h103, 2'b00, 1'b1), 32'h0000_0080);
        checkOutput("model_be_byte", {28'd0, modelBe(2'b00, 32'h103)}, 32'h8);
        checkOutput("model_be_half", {28'd0, modelBe(2'b01, 32'h202)}, 32'hC);
        checkOutput("model_be_word", {28'd0, modelBe(2'b10, 32'h100)}, 32'hF);
        checkOutput("model_wd_half", modelWdata(2'b01, 32'h0000_ABCD), 32'hABCD_ABCD);
        checkOutput("model_wd_byte", modelWdata(2'b00, 32'h0000_005A), 32'h5A5A_5A5A);
        checkOutput("model_ld_shalf", modelLoad(32'h8001_7FFF, 32'h002, 2'b01, 1'b0), 32'hFFFF_8001);

        @(posedge clk);
        nextCycle();
        expAddr = '0; expBe = '0; expWe = 1'b0; expWdata = '0;
        setExp(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        nextCycle();
        rst = 1'b0;

        applyStimulus(32'h100, 32'h0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 2, 32'hDEAD_BEEF);
        applyStimulus(32'h103, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1, 32'h8011_2233);
        applyStimulus(32'h103, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b1, 3, 32'h8011_2233);
        applyStimulus(32'h202, 32'h0000_ABCD, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1, 32'h1234_5678);
        applyStimulus(32'h0, 32'h0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 0, 32'h0);
        applyStimulus(32'h400, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 0, 32'h5555_AAAA);
        applyStimulus(32'h404, 32'h0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1, 2'b11, 1'b0, T, 32'hCAFE_F00D);
        applyStimulus(32'h101, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1, 32'h0BAD_F00D);

        // Reset lands in the third REQ cycle; an ack arriving afterwards must not revive the access.
        ALUresultin = 32'h300; MemReadin = 1'b1; MemWritein = 1'b0; Regwritein = 1'b1;
        mem_size = 2'b10; mem_unsigned = 1'b0; mem_ack = 1'b0;
        setExp(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        nextCycle();
        expAddr = 32'h300; expBe = 4'hF; expWe = 1'b0; expWdata = storedatain;
        for (int c = 1; c <= 3; c++) begin
            rst = (c == 3);
            setExp(1'b1, 1'b1, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1);
            nextCycle();
        end
        rst = 1'b0; MemReadin = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        expAddr = '0; expBe = '0; expWe = 1'b0; expWdata = '0;
        setExp(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        nextCycle();
        mem_ack = 1'b0;
        setExp(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(32'h300, 32'h0, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1, 32'h1357_9BDF);

        for (int n = 0; n < 80; n++) begin
            int          kind, ackAt;
            logic        rdEn, wrEn;
            kind  = $urandom_range(0, 9);
            rdEn  = (kind < 5);
            wrEn  = (kind >= 5) && (kind < 8);
            ackAt = $urandom_range(1, 5);
            if ($urandom_range(0, 9) == 0) ackAt = 0;
            if ($urandom_range(0, 9) == 0) ackAt = T;
            applyStimulus($urandom, $urandom, 5'($urandom), rdEn, wrEn, 1'($urandom), 1'($urandom),
                          2'($urandom), 1'($urandom), ackAt, $urandom);
        end

        expValid = 1'b0;
        @(posedge clk);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
